// File: rtl/alu4_seq_pkg.sv
// alu4_seq_pkg: shared constants, FSM states and Booth op encoding for alu4_booth_seq
package alu4_seq_pkg;

    localparam int N_BITS  = 4;
    localparam int N_STEPS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_e;

    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        return ({q0, q_1} == 2'b01) ? OP_ADD : ({q0, q_1} == 2'b10) ? OP_SUB : OP_NOP;
    endfunction

endpackage

// File: rtl/alu4_addsub.sv
// alu4_addsub: combinational 4-bit ripple add/sub, ovf = carry4 ^ carry3
module alu4_addsub
    import alu4_seq_pkg::*;
(
    input  logic [N_BITS-1:0] x,
    input  logic [N_BITS-1:0] y,
    input  logic              sub,
    output logic [N_BITS-1:0] s,
    output logic              ovf
);

    logic [N_BITS:0]   c;
    logic [N_BITS-1:0] yb;

    always_comb begin
        s    = '0;
        c    = '0;
        yb   = y ^ {N_BITS{sub}};
        c[0] = sub;
        for (int i = 0; i < N_BITS; i++) begin
            s[i]   = x[i] ^ yb[i] ^ c[i];
            c[i+1] = (x[i] & yb[i]) | (c[i] & (x[i] ^ yb[i]));
        end
        ovf = c[N_BITS] ^ c[N_BITS-1];
    end

endmodule

// File: rtl/alu4_booth_seq.sv
// alu4_booth_seq: sequential signed 4x4 radix-2 Booth multiplier, one step per clock.
// Optional completed-product counter port op_count when ALU4_SEQ_CNT_EN is defined.
module alu4_booth_seq
    import alu4_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   a,
    input  logic [N_BITS-1:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*N_BITS-1:0] product
`ifdef ALU4_SEQ_CNT_EN
    ,
    output logic [7:0]          op_count
`endif
);

    state_e            state_q, state_d;
    logic [N_BITS-1:0] m_q, m_d, acc_q, acc_d, mul_q, mul_d;
    logic              q1_q, q1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    booth_op_e         op;
    logic [N_BITS-1:0] y, s;
    logic              ovf;

    // NOP adds zero so the single adder also passes A through with ovf=0
    assign op = booth_op(mul_q[0], q1_q);
    assign y  = (op == OP_NOP) ? '0 : m_q;

    alu4_addsub u_addsub (
        .x   (acc_q),
        .y   (y),
        .sub (op == OP_SUB),
        .s   (s),
        .ovf (ovf)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                m_d     = a;
                mul_d   = b;
                acc_d   = '0;
                q1_d    = 1'b0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                // sign corrected by ovf keeps A:Q exact when M = -8
                acc_d   = {s[N_BITS-1] ^ ovf, s[N_BITS-1:1]};
                mul_d   = {s[0], mul_q[N_BITS-1:1]};
                q1_d    = mul_q[0];
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'(N_STEPS - 1)) ? DONE : CALC;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            acc_q       <= '0;
            mul_q       <= '0;
            q1_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            mul_q       <= mul_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = {acc_q, mul_q};

`ifdef ALU4_SEQ_CNT_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb op_count_d = op_count_q + 8'(out_valid_q && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu4_booth_seq.sv
// tb_alu4_booth_seq: directed self-checking bench for alu4_booth_seq (ALU4_SEQ_CNT_EN optional)
module tb_alu4_booth_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       in_ready, out_valid;
    logic [7:0] product;
`ifdef ALU4_SEQ_CNT_EN
    logic [7:0] op_count;
`endif
    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    alu4_booth_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef ALU4_SEQ_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_done(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, 16'(out_valid), 16'd0);
        chk({tag, "_ir_high"}, 16'(in_ready), 16'd1);
    endtask

    task automatic mul(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp, input string tag);
        int n;
        start(x, y);
        wait_valid(n);
        chk({tag, "_lat"}, 16'(n), 16'd4);
        chk({tag, "_prod"}, 16'(product), 16'(exp));
        release_done(tag);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_product", 16'(product), 16'd0);
`ifdef ALU4_SEQ_CNT_EN
        chk("rst_op_count", 16'(op_count), 16'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 16'(in_ready), 16'd1);

        mul(4'd3, 4'd5, 8'h0F, "3x5");
        mul(4'hD, 4'd5, 8'hF1, "m3x5");
        mul(4'd7, 4'h8, 8'hC8, "7xm8");
        mul(4'h8, 4'h8, 8'h40, "m8xm8");
        mul(4'h8, 4'hF, 8'h08, "m8xm1");
        mul(4'h8, 4'd7, 8'hC8, "m8x7");
        mul(4'd7, 4'd7, 8'h31, "7x7");
        mul(4'd0, 4'hB, 8'h00, "0xm5");

        start(4'd2, 4'd3);
        wait_valid(lat);
        chk("hold_lat", 16'(lat), 16'd4);
        chk("hold_prod0", 16'(product), 16'h06);
        a = 4'd5;
        b = 4'd5;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_prod", 16'(product), 16'h06);
            chk("hold_in_ready", 16'(in_ready), 16'd0);
            chk("hold_out_valid", 16'(out_valid), 16'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_exit_ir", 16'(in_ready), 16'd1);
        chk("hold_exit_ov", 16'(out_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("queued_lat", 16'(lat), 16'd4);
        chk("queued_prod", 16'(product), 16'h19);
        release_done("queued");

        start(4'd3, 4'd5);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 16'(in_ready), 16'd0);
        chk("abort_out_valid", 16'(out_valid), 16'd0);
        chk("abort_product", 16'(product), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rel_ir", 16'(in_ready), 16'd1);
        chk("abort_rel_ov", 16'(out_valid), 16'd0);
        mul(4'hF, 4'hF, 8'h01, "m1xm1");

`ifdef ALU4_SEQ_CNT_EN
        begin
            int n = 0;
            int cyc = 0;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("cnt_rst", 16'(op_count), 16'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            a = 4'd1;
            b = 4'd1;
            in_valid = 1'b1;
            out_ready = 1'b1;
            while (n < 257 && cyc < 3000) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (out_valid) n++;
            end
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk("cnt_products", 16'(n), 16'd257);
            chk("cnt_wrap", 16'(op_count), 16'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
